quad_decoder: RTL and testbench
===============================

// Module: quad_decoder
// PURPOSE
//  Converts raw rotary-encoder quadrature lines (A/B) into clean single-cycle
//  cw/ccw step pulses for the encoder-to-frequency mapper and other UI consumers.
//  Synchronises and debounces each channel, then decodes Gray-code transitions.
//  Also keeps a signed position count and an illegal-transition error count.
//  Sits between the board encoder pins and enc2freq-style consumers.
//  One detent = 4 quadrature steps = 4 pulses.
// PARAMETERS
//  SYNC_STAGES      2    flip-flop stages per input synchroniser (>=2)
//  DEBOUNCE_CYCLES  500  consecutive stable clk cycles before a channel change commits (>=1)
//  POS_W            16   width of signed position counter
//  ERR_W            8    width of saturating error counter
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      reset, asynchronous, active-low
//  a_raw      in   1      encoder channel A, asynchronous to clk
//  b_raw      in   1      encoder channel B, asynchronous to clk
//  pos_clr    in   1      synchronous clear of pos
//  err_clr    in   1      synchronous clear of err_count
//  cw         out  1      1-cycle pulse per clockwise quadrature step
//  ccw        out  1      1-cycle pulse per counter-clockwise quadrature step
//  err        out  1      1-cycle pulse on illegal (double-bit) transition
//  locked     out  1      high once initial state is captured (TRACK state)
//  pos        out  POS_W  signed step count, +1 per cw, -1 per ccw
//  err_count  out  ERR_W  illegal transitions since reset/clear, saturating
// BEHAVIOUR
//  Reset values: cw=ccw=err=locked=0, pos=0, err_count=0; sync/debounce regs=0; FSM=INIT.
//  Sync: each raw input passes through SYNC_STAGES FFs. Nothing else samples a_raw/b_raw.
//  Debounce (per channel):
//   - Counter runs while synced value != committed value.
//   - Any bounce back to the committed value zeroes the counter.
//   - Commit occurs after DEBOUNCE_CYCLES consecutive unequal cycles.
//  FSM INIT:
//   - Waits until both channels are stable for DEBOUNCE_CYCLES.
//   - Then loads prev={A,B} with no pulse, sets locked=1 and goes to TRACK.
//  FSM TRACK:
//   - On any commit, compare new {A,B} with prev.
//   - Update prev the same cycle.
//  Decode ({A,B}): CW sequence 00->10->11->01->00 (A leads B); CCW is the reverse.
//   - Single-bit change in CW order  -> cw=1 next cycle.
//   - Single-bit change in CCW order -> ccw=1 next cycle.
//   - Both bits change (incl. both channels committing the same cycle) -> err=1,
//     err_count+1, no cw/ccw, prev takes new value.
//   - cw and ccw are never high together. Every pulse lasts exactly 1 cycle.
//  Latency: SYNC_STAGES+DEBOUNCE_CYCLES cycles from the first clk edge sampling a
//   stable new raw level to the rising cw/ccw/err.
//  pos: two's-complement, wraps mod 2^POS_W; updates in the same cycle cw/ccw is high.
//   - pos_clr wins over a concurrent step: pos=0.
//  err_count: saturates at 2^ERR_W-1.
//   - err_clr alone -> 0.
//   - err_clr with a concurrent err -> 1.
//  Reset mid-operation: all state returns to reset values, FSM returns to INIT.
//   - No pulse until INIT completes again.
// STRUCTURE
//  Package quad_pkg:
//   - typedef enum logic {INIT, TRACK} qd_state_t.
//   - typedef logic [1:0] quad_t.
//   - localparam quad_t Q00/Q10/Q11/Q01.
//   - function quad_t cw_next(quad_t).
//  Sub-module quad_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES):
//   - Ports: clk, reset_n, raw -> level, commit (1-cycle), stable.
//   - Instantiated twice, once for A and once for B.
//  Top holds the FSM, decode logic, pos and err counters.
// TESTING (bench: SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//  1 Release reset with a=b=1 held -> locked rises after 6 cycles.
//    No cw/ccw/err; pos=0.
//  2 From 11, apply 01,00,10,11, each held 10 cycles.
//    -> 4 cw pulses, each 6 cycles after its change; pos=4.
//  3 From a steady state, toggle a_raw for 3 cycles and restore.
//    -> no commit, no pulse, pos unchanged.
//  4 From 00, change both lines to 11 together.
//    -> err 1 cycle, err_count=1, no cw/ccw.
//    Then err_clr -> err_count=0.
//  5 From pos=0, apply 4 CCW steps -> pos=16'hFFFC.
//    Then pos_clr in the same cycle as a ccw pulse -> pos=0.
//  6 Assert reset_n mid-debounce for 2 cycles.
//    -> all outputs 0 immediately, locked=0.
//    No pulse until INIT re-completes, even if lines differ from before.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and Gray-code helpers for the quadrature decoder.
package quad_pkg;

  typedef enum logic {INIT, TRACK} qd_state_t;

  typedef logic [1:0] quad_t;

  localparam quad_t Q00 = 2'b00;
  localparam quad_t Q10 = 2'b10;
  localparam quad_t Q11 = 2'b11;
  localparam quad_t Q01 = 2'b01;

  // {A,B} clockwise successor: 00 -> 10 -> 11 -> 01 -> 00 (A leads B)
  function automatic quad_t cw_next(input quad_t q);
    quad_t n;
    case (q)
      Q00:     n = Q10;
      Q10:     n = Q11;
      Q11:     n = Q01;
      default: n = Q00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// Per-channel synchroniser and debouncer: commits a new level after
// DEBOUNCE_CYCLES consecutive cycles of disagreement with the committed level.
module quad_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic commit,
  output logic stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       bounce_cnt;
  logic [CNT_W-1:0]       quiet_cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      level      <= 1'b0;
      commit     <= 1'b0;
      stable     <= 1'b0;
      bounce_cnt <= '0;
      quiet_cnt  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      commit <= 1'b0;
      if (synced != level) begin
        quiet_cnt <= '0;
        if (bounce_cnt == LAST) begin
          level      <= synced;
          commit     <= 1'b1;
          stable     <= 1'b1;
          bounce_cnt <= '0;
        end else begin
          bounce_cnt <= bounce_cnt + 1'b1;
          stable     <= 1'b0;
        end
      end else begin
        bounce_cnt <= '0;
        // a channel that never moved still has to sit quiet for the full window
        if (!stable) begin
          if (quiet_cnt == LAST) stable <= 1'b1;
          else                   quiet_cnt <= quiet_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Rotary-encoder quadrature decoder: debounced A/B channels feed a Gray-code
// step decoder with cw/ccw/err pulses, a signed position and an error count.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int POS_W           = 16,
  parameter int ERR_W           = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    a_raw,
  input  logic                    b_raw,
  input  logic                    pos_clr,
  input  logic                    err_clr,
  output logic                    cw,
  output logic                    ccw,
  output logic                    err,
  output logic                    locked,
  output logic signed [POS_W-1:0] pos,
  output logic        [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic a_level, a_commit, a_stable;
  logic b_level, b_commit, b_stable;

  quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (a_raw),
    .level   (a_level),
    .commit  (a_commit),
    .stable  (a_stable)
  );

  quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (b_raw),
    .level   (b_level),
    .commit  (b_commit),
    .stable  (b_stable)
  );

  qd_state_t state;
  quad_t     prev_ab;
  quad_t     cur_ab;
  logic      any_commit;
  logic      step_cw;
  logic      step_ccw;
  logic      step_err;

  always_comb begin
    cur_ab     = {a_level, b_level};
    any_commit = a_commit | b_commit;
    step_cw    = (state == TRACK) && any_commit && (cur_ab == cw_next(prev_ab));
    step_ccw   = (state == TRACK) && any_commit && (prev_ab == cw_next(cur_ab));
    step_err   = (state == TRACK) && any_commit && (cur_ab == ~prev_ab);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      prev_ab   <= Q00;
      cw        <= 1'b0;
      ccw       <= 1'b0;
      err       <= 1'b0;
      locked    <= 1'b0;
      pos       <= '0;
      err_count <= '0;
    end else begin
      cw  <= 1'b0;
      ccw <= 1'b0;
      err <= 1'b0;
      case (state)
        INIT: begin
          // commits seen while locking only establish the starting position
          if (a_stable && b_stable) begin
            prev_ab <= cur_ab;
            locked  <= 1'b1;
            state   <= TRACK;
          end
        end
        TRACK: begin
          if (any_commit) begin
            prev_ab <= cur_ab;
            cw      <= step_cw;
            ccw     <= step_ccw;
            err     <= step_err;
          end
        end
        default: state <= INIT;
      endcase

      if (pos_clr)       pos <= '0;
      else if (step_cw)  pos <= pos + 1'b1;
      else if (step_ccw) pos <= pos - 1'b1;

      if (err_clr)
        err_count <= step_err ? ERR_W'(1) : '0;
      else if (step_err && err_count != ERR_MAX)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_quad_decoder;

  localparam int LAT = 7;  // drive at negedge of cycle c; pulse seen at negedge of c+7
  localparam int K_CW = 0, K_CCW = 1, K_ERR = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_raw = 1'b1, b_raw = 1'b1;
  logic        pos_clr = 1'b0, err_clr = 1'b0;
  logic        cw, ccw, err, locked;
  logic [15:0] pos;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] pos;
    logic [7:0]  errc;
  } exp_t;
  exp_t sb_q[$];

  quad_decoder #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .POS_W(16), .ERR_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_raw     (a_raw),
    .b_raw     (b_raw),
    .pos_clr   (pos_clr),
    .err_clr   (err_clr),
    .cw        (cw),
    .ccw       (ccw),
    .err       (err),
    .locked    (locked),
    .pos       (pos),
    .err_count (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    int kind;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (cw || ccw || err)) begin
        kind = cw ? K_CW : (ccw ? K_CCW : K_ERR);
        check("one_hot_pulse", 32'(cw) + 32'(ccw) + 32'(err), 1);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d with no pulse expected (cycle %0d)", kind, cyc);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind", kind, e.kind);
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_pos", 32'(pos), 32'(e.pos));
          check("pulse_errc", 32'(err_count), 32'(e.errc));
        end
      end
    end
  endtask

  // drive a new {A,B}, expect one pulse; optional clears land on the decode edge
  task automatic step(input logic [1:0] ab, input int kind, input logic [15:0] p,
                      input logic [7:0] ec, input bit pclr, input bit eclr);
    exp_t e;
    @(negedge clk);
    a_raw = ab[1];
    b_raw = ab[0];
    e.kind = kind;
    e.cyc  = cyc + LAT;
    e.pos  = p;
    e.errc = ec;
    sb_q.push_back(e);
    repeat (LAT - 1) @(negedge clk);
    pos_clr = pclr;
    err_clr = eclr;
    @(negedge clk);
    pos_clr = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_lock(input string name);
    int c0;
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (locked) break;
    end
    check(name, cyc - c0, LAT);
  endtask

  task automatic stimulus();
    // 1: reset state, then lock from 11
    repeat (3) @(negedge clk);
    check("rst_cw", {cw, ccw, err}, 0);
    check("rst_locked", locked, 0);
    check("rst_pos", pos, 0);
    check("rst_errc", err_count, 0);
    reset_n = 1'b1;
    wait_lock("lock_latency");
    check("lock_pos", pos, 0);
    repeat (4) @(negedge clk);

    // 2: four clockwise steps from 11
    step(2'b01, K_CW, 16'd1, 8'd0, 1'b0, 1'b0);
    step(2'b00, K_CW, 16'd2, 8'd0, 1'b0, 1'b0);
    step(2'b10, K_CW, 16'd3, 8'd0, 1'b0, 1'b0);
    step(2'b11, K_CW, 16'd4, 8'd0, 1'b0, 1'b0);
    check("cw_pos", pos, 16'd4);

    // 3: 3-cycle glitch on A must not commit
    @(negedge clk);
    a_raw = 1'b0;
    repeat (3) @(negedge clk);
    a_raw = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_pos", pos, 16'd4);

    // 4: double-bit change, clear, then clear concurrent with an error
    step(2'b01, K_CW, 16'd5, 8'd0, 1'b0, 1'b0);
    step(2'b00, K_CW, 16'd6, 8'd0, 1'b0, 1'b0);
    step(2'b11, K_ERR, 16'd6, 8'd1, 1'b0, 1'b0);
    check("err_count_one", err_count, 8'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", err_count, 8'd0);
    step(2'b00, K_ERR, 16'd6, 8'd1, 1'b0, 1'b1);
    check("err_clr_with_err", err_count, 8'd1);

    // 5: counter-clockwise underflow, then pos_clr racing a ccw step
    pos_clr = 1'b1;
    @(negedge clk);
    pos_clr = 1'b0;
    check("pos_clr", pos, 16'd0);
    step(2'b01, K_CCW, 16'hFFFF, 8'd1, 1'b0, 1'b0);
    step(2'b11, K_CCW, 16'hFFFE, 8'd1, 1'b0, 1'b0);
    step(2'b10, K_CCW, 16'hFFFD, 8'd1, 1'b0, 1'b0);
    step(2'b00, K_CCW, 16'hFFFC, 8'd1, 1'b0, 1'b0);
    check("ccw_pos", pos, 16'hFFFC);
    step(2'b01, K_CCW, 16'd0, 8'd1, 1'b1, 1'b0);
    check("pos_clr_wins", pos, 16'd0);
    step(2'b00, K_CW, 16'd1, 8'd1, 1'b0, 1'b0);

    // 6: reset mid-debounce, relock onto a different line state
    @(negedge clk);
    a_raw = 1'b1;
    b_raw = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_pos", pos, 0);
    check("mid_rst_errc", err_count, 0);
    check("mid_rst_pulses", {cw, ccw, err}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_lock("relock_latency");
    repeat (4) @(negedge clk);
    step(2'b11, K_CW, 16'd1, 8'd0, 1'b0, 1'b0);
    check("final_pos", pos, 16'd1);

    repeat (10) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
